mem_bus_router: RTL and testbench
=================================

// Module: mem_bus_router
// PURPOSE
//  Registered, parametrised successor to the MCU combinational memory decoder. Accepts one
//  master request at a time, decodes the region from the upper address bits, and forwards the
//  request to one of N_REGIONS slave ports (BRAM, SRAM, flash, peripherals, ...). Returns the
//  slave's read data, or an error response for an unmapped address or a slave timeout.
//  Sits between the CPU load/store unit and the memory/peripheral slaves.
// PARAMETERS
//  ADDR_W         32   address width
//  DATA_W         32   data width
//  SEL_W          16   region-select field = addr[ADDR_W-1 -: SEL_W]
//  N_REGIONS      4    slave count; region i <=> select field == i (1..2**SEL_W)
//  TIMEOUT_CYCLES 255  max cycles in ISSUE+WAIT before error (TIMEOUT_EN only); >=1
// PORTS
//  clk           in   1                  clock, rising edge
//  rst           in   1                  asynchronous, active-high reset
//  m_req_valid   in   1                  master request valid
//  m_req_ready   out  1                  router can accept a request (high only in IDLE)
//  m_addr        in   ADDR_W             request address
//  m_we          in   1                  1=write, 0=read
//  m_wdata       in   DATA_W             write data
//  m_rsp_valid   out  1                  response valid
//  m_rsp_ready   in   1                  master accepts response
//  m_rdata       out  DATA_W             read data (0 on error and on writes)
//  m_rsp_err     out  1                  unmapped address or timeout
//  s_req_valid   out  N_REGIONS          one-hot request to the selected slave
//  s_req_ready   in   N_REGIONS          per-slave accept
//  s_addr        out  ADDR_W-SEL_W       region-relative offset (shared by all slaves)
//  s_we          out  1                  shared write enable
//  s_wdata       out  DATA_W             shared write data
//  s_rsp_valid   in   N_REGIONS          per-slave response valid
//  s_rdata       in   N_REGIONS*DATA_W   slave i data in [i*DATA_W +: DATA_W]
//  err_count     out  16                 saturating count of error responses
// BEHAVIOUR
//  Reset: state=IDLE; m_req_ready=1; m_rsp_valid=0; m_rsp_err=0; m_rdata=0; s_req_valid=0;
//   s_addr/s_we/s_wdata=0; err_count=0; timeout counter=0. Reset mid-transaction aborts it; no response.
//  FSM:
//   IDLE : m_req_ready=1. On m_req_valid: register addr offset/we/wdata/sel.
//          Select field < N_REGIONS -> ISSUE; else -> RESP with err=1, rdata=0.
//   ISSUE: s_req_valid[sel]=1 (all others 0), held with stable s_addr/s_we/s_wdata
//          until s_req_ready[sel] -> WAIT. Ready from non-selected slaves is ignored.
//   WAIT : On s_rsp_valid[sel]: capture s_rdata slice (0 if write), err=0 -> RESP.
//          s_rsp_valid in ISSUE, or from non-selected slaves, is ignored.
//   RESP : m_rsp_valid=1; m_rdata/m_rsp_err held stable until m_rsp_ready -> IDLE.
//  Latency: decode error -> m_rsp_valid the cycle after acceptance. Zero-wait slave
//   (ready and rsp both immediate) -> m_rsp_valid 3 cycles after acceptance.
//  One outstanding transaction; no new request accepted before the response handshake completes.
//  err_count increments on entry to RESP with err=1; saturates at 16'hFFFF (no wrap).
// CONFIGURATION
//  MEM_BUS_ROUTER_TIMEOUT_EN defined: a counter clears on entering ISSUE and increments every
//   ISSUE/WAIT cycle. When it reaches TIMEOUT_CYCLES without completion: drop s_req_valid ->
//   RESP with err=1, rdata=0. A slave response on the same cycle as the timeout wins (no error).
//  Undefined: no counter; ISSUE/WAIT wait indefinitely.
// STRUCTURE
//  Package mem_bus_pkg: state encoding (IDLE/ISSUE/WAIT/RESP), err_count width, and the
//   region-index constants (BRAM=0, SRAM=1, FLASH=2, PERIPH=3).
//  Sub-module mem_region_decode: combinational; addr -> sel index + hit flag.
// TESTING
//  1 read 0x0000_0010, slave0 ready+rsp immediately, rdata=0xDEADBEEF -> s_addr=0x0010,
//    m_rdata=0xDEADBEEF, err=0, m_rsp_valid 3 cycles after acceptance.
//  2 write 0x0003_0004 data 0x55 -> only s_req_valid[3] high; s_we=1, s_wdata=0x55; m_rdata=0.
//  3 addr 0x0004_0000 (N_REGIONS=4) -> no s_req_valid; err=1 next cycle; err_count=1.
//  4 m_rsp_ready low 5 cycles in RESP -> response held stable; m_req_ready=0 throughout.
//  5 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave2 never responds -> err=1 after 8 cycles; same-cycle
//    rsp+timeout -> no error.
//  6 rst asserted in WAIT -> all outputs at reset values asynchronously; next request works.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the registered memory bus router.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int unsigned ERR_CNT_W = 16;

  localparam int unsigned REGION_BRAM   = 0;
  localparam int unsigned REGION_SRAM   = 1;
  localparam int unsigned REGION_FLASH  = 2;
  localparam int unsigned REGION_PERIPH = 3;

  localparam int unsigned N_DEFAULT_REGIONS = REGION_PERIPH + 1;

  // Saturating increment used by the error counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational region decoder: select field -> slave index plus mapped/unmapped flag.
module mem_region_decode
  import mem_bus_pkg::*;
#(
  parameter int unsigned SEL_W     = 16,
  parameter int unsigned N_REGIONS = N_DEFAULT_REGIONS,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [SEL_W-1:0] sel_field,
  output logic [IDX_W-1:0] sel_idx_c,
  output logic             hit_c
);

  localparam logic [SEL_W:0] N_REG_LIM = (SEL_W+1)'(N_REGIONS);

  always_comb begin
    hit_c     = ({1'b0, sel_field} < N_REG_LIM);
    sel_idx_c = IDX_W'(sel_field);
  end

endmodule

// File: rtl/mem_bus_router.sv
// Registered single-outstanding router from one master to N_REGIONS slaves.
// Optional slave timeout enabled by defining MEM_BUS_ROUTER_TIMEOUT_EN.
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SEL_W          = 16,
  parameter int unsigned N_REGIONS      = N_DEFAULT_REGIONS,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        m_req_valid,
  output logic                        m_req_ready,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic                        m_we,
  input  logic [DATA_W-1:0]           m_wdata,
  output logic                        m_rsp_valid,
  input  logic                        m_rsp_ready,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_rsp_err,
  output logic [N_REGIONS-1:0]        s_req_valid,
  input  logic [N_REGIONS-1:0]        s_req_ready,
  output logic [ADDR_W-SEL_W-1:0]     s_addr,
  output logic                        s_we,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic [N_REGIONS-1:0]        s_rsp_valid,
  input  logic [N_REGIONS*DATA_W-1:0] s_rdata,
  output logic [ERR_CNT_W-1:0]        err_count
);

  localparam int unsigned OFF_W = ADDR_W - SEL_W;
  localparam int unsigned IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_err
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [OFF_W-1:0]       s_addr_q, s_addr_d;
  logic                   s_we_q, s_we_d;
  logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
  logic [N_REGIONS-1:0]   s_req_valid_q, s_req_valid_d;
  logic                   m_req_ready_q, m_req_ready_d;
  logic                   m_rsp_valid_q, m_rsp_valid_d;
  logic                   m_rsp_err_q, m_rsp_err_d;
  logic [DATA_W-1:0]      m_rdata_q, m_rdata_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  logic [IDX_W-1:0]       dec_idx_c;
  logic                   dec_hit_c;
  logic                   tmo_hit_c;

  mem_region_decode #(
    .SEL_W     (SEL_W),
    .N_REGIONS (N_REGIONS),
    .IDX_W     (IDX_W)
  ) u_decode (
    .sel_field (m_addr[ADDR_W-1 -: SEL_W]),
    .sel_idx_c (dec_idx_c),
    .hit_c     (dec_hit_c)
  );

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts cycles spent in ISSUE/WAIT; zero whenever the router is elsewhere.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_hit_c = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    s_addr_d      = s_addr_q;
    s_we_d        = s_we_q;
    s_wdata_d     = s_wdata_q;
    m_rsp_err_d   = m_rsp_err_q;
    m_rdata_d     = m_rdata_q;
    err_count_d   = err_count_q;
    s_req_valid_d = '0;
    m_req_ready_d = 1'b0;
    m_rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m_req_valid) begin
          s_addr_d  = m_addr[OFF_W-1:0];
          s_we_d    = m_we;
          s_wdata_d = m_wdata;
          sel_d     = dec_idx_c;
          if (dec_hit_c) begin
            state_d = ST_ISSUE;
          end else begin
            state_d     = ST_RESP;
            m_rsp_err_d = 1'b1;
            m_rdata_d   = '0;
          end
        end
      end
      ST_ISSUE: begin
        // A grant on the timeout cycle is not a completion, so timeout still wins.
        if (tmo_hit_c) begin
          state_d     = ST_RESP;
          m_rsp_err_d = 1'b1;
          m_rdata_d   = '0;
        end else if (s_req_ready[sel_q]) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_rsp_valid[sel_q]) begin
          state_d     = ST_RESP;
          m_rsp_err_d = 1'b0;
          m_rdata_d   = s_we_q ? '0 : s_rdata[int'(sel_q)*DATA_W +: DATA_W];
        end else if (tmo_hit_c) begin
          state_d     = ST_RESP;
          m_rsp_err_d = 1'b1;
          m_rdata_d   = '0;
        end
      end
      ST_RESP: begin
        if (m_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    m_req_ready_d = (state_d == ST_IDLE);
    m_rsp_valid_d = (state_d == ST_RESP);
    if (state_d == ST_ISSUE) begin
      s_req_valid_d = N_REGIONS'(1) << sel_d;
    end
    if (state_d == ST_RESP && state_q != ST_RESP && m_rsp_err_d) begin
      err_count_d = sat_inc(err_count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      s_addr_q      <= '0;
      s_we_q        <= 1'b0;
      s_wdata_q     <= '0;
      s_req_valid_q <= '0;
      m_req_ready_q <= 1'b1;
      m_rsp_valid_q <= 1'b0;
      m_rsp_err_q   <= 1'b0;
      m_rdata_q     <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      s_addr_q      <= s_addr_d;
      s_we_q        <= s_we_d;
      s_wdata_q     <= s_wdata_d;
      s_req_valid_q <= s_req_valid_d;
      m_req_ready_q <= m_req_ready_d;
      m_rsp_valid_q <= m_rsp_valid_d;
      m_rsp_err_q   <= m_rsp_err_d;
      m_rdata_q     <= m_rdata_d;
      err_count_q   <= err_count_d;
    end
  end

  assign m_req_ready = m_req_ready_q;
  assign m_rsp_valid = m_rsp_valid_q;
  assign m_rsp_err   = m_rsp_err_q;
  assign m_rdata     = m_rdata_q;
  assign s_req_valid = s_req_valid_q;
  assign s_addr      = s_addr_q;
  assign s_we        = s_we_q;
  assign s_wdata     = s_wdata_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_mem_bus_router.sv
// Bench for mem_bus_router: directed table, random traffic against a latency/response model,
// and hand sequences for reset-in-flight and (when MEM_BUS_ROUTER_TIMEOUT_EN) timeouts.
module tb_mem_bus_router;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 16;
  localparam int TMO = 8;

  logic            clk, rst;
  logic            m_req_valid, m_req_ready;
  logic [AW-1:0]   m_addr;
  logic            m_we;
  logic [DW-1:0]   m_wdata;
  logic            m_rsp_valid, m_rsp_ready;
  logic [DW-1:0]   m_rdata;
  logic            m_rsp_err;
  logic [N-1:0]    s_req_valid, s_req_ready;
  logic [AW-SW-1:0] s_addr;
  logic            s_we;
  logic [DW-1:0]   s_wdata;
  logic [N-1:0]    s_rsp_valid;
  logic [N*DW-1:0] s_rdata;
  logic [15:0]     err_count;

  logic [DW-1:0]   slv_data [N];

  mem_bus_router #(
    .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .N_REGIONS(N), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_addr(m_addr),
    .m_we(m_we), .m_wdata(m_wdata), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rdata(m_rdata), .m_rsp_err(m_rsp_err), .s_req_valid(s_req_valid),
    .s_req_ready(s_req_ready), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rdata(s_rdata), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) s_rdata[i*DW +: DW] = slv_data[i];
  end

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  // Slave behaviour knobs, written only by the stimulus process.
  int cur_slv = -1;
  int rdy_lat = 0;
  int rsp_lat = 0;
  bit never_rsp = 0;
  bit noise_en = 0;

  // Slave model state, written only by the slave process.
  int iss_cnt, wcnt;
  bit hs_pend, in_wait;
  logic [N-1:0] rdy_v, rsp_v;

  // Target slave grants after rdy_lat cycles of request, answers rsp_lat cycles into the wait;
  // other slaves (and the target outside its wait) may toggle noise that the router must ignore.
  always @(negedge clk) begin
    rdy_v = noise_en ? N'($urandom) : '0;
    rsp_v = noise_en ? N'($urandom) : '0;
    if (rst || m_req_ready) begin
      iss_cnt = 0; wcnt = 0; hs_pend = 0; in_wait = 0;
    end else begin
      if (hs_pend) begin in_wait = 1; wcnt = 0; hs_pend = 0; end
      if (cur_slv >= 0) begin
        rdy_v[cur_slv] = 1'b0;
        if (s_req_valid[cur_slv] && !in_wait) begin
          if (iss_cnt >= rdy_lat) begin rdy_v[cur_slv] = 1'b1; hs_pend = 1; end
          iss_cnt++;
        end
        if (in_wait) begin
          rsp_v[cur_slv] = 1'b0;
          if (!never_rsp && wcnt == rsp_lat) begin rsp_v[cur_slv] = 1'b1; in_wait = 0; end
          wcnt++;
        end
      end
    end
    s_req_ready = rdy_v;
    s_rsp_valid = rsp_v;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: unmapped -> error next cycle; otherwise ISSUE lasts rl+1, WAIT lasts sl+1,
  // and with a timeout any transaction needing more than TMO ISSUE/WAIT cycles errors out.
  function automatic void ref_model(input logic [31:0] addr, input bit we, input int rl,
                                    input int sl, input bit nv, output bit err,
                                    output logic [31:0] rd, output int lat);
    int sel = int'(addr[31:16]);
    int busy = rl + sl + 2;
    if (sel >= N) begin
      err = 1; rd = 0; lat = 1;
      return;
    end
`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
    if (nv || busy > TMO) begin
      err = 1; rd = 0; lat = TMO + 1;
      return;
    end
`endif
    err = 0;
    rd = we ? 32'h0 : slv_data[sel];
    lat = busy + 1;
  endfunction

  task automatic run_txn(input string nm, input logic [31:0] addr, input bit we,
                         input logic [31:0] wd, input int rl, input int sl, input bit nv,
                         input int hold, input bit exp_err, input logic [31:0] exp_rd,
                         input int exp_lat);
    int sel = int'(addr[31:16]);
    bit hit = (sel < N);
    logic [N-1:0] mask;
    logic [15:0] off = addr[15:0];
    int lat, g;
    bit bad_mask, seen, fld_bad, rdy_bad, stab_bad;
    logic [31:0] rd_hold;
    logic err_hold;
    mask = hit ? (N'(1) << sel) : '0;
    cur_slv = hit ? sel : -1;
    rdy_lat = rl; rsp_lat = sl; never_rsp = nv;
    g = 0;
    while (!m_req_ready && g < 50) begin @(posedge clk); #1; g++; end
    m_addr = addr; m_we = we; m_wdata = wd; m_req_valid = 1'b1;
    @(posedge clk); #1;
    m_req_valid = 1'b0;
    lat = 1; bad_mask = 0; seen = 0; fld_bad = 0; rdy_bad = 0; stab_bad = 0;
    while (!m_rsp_valid && lat < 300) begin
      if ((s_req_valid & ~mask) != '0) bad_mask = 1;
      if ((s_req_valid & mask) != '0) begin
        seen = 1;
        if (s_addr !== off || s_we !== we || s_wdata !== wd) fld_bad = 1;
      end
      if (m_req_ready) rdy_bad = 1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s_lat", nm), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s_err", nm), 64'(m_rsp_err), 64'(exp_err));
    chk($sformatf("%s_rdata", nm), 64'(m_rdata), 64'(exp_rd));
    chk($sformatf("%s_sreq_other", nm), 64'(bad_mask), 64'(0));
    chk($sformatf("%s_sreq_seen", nm), 64'(seen), 64'(hit));
    chk($sformatf("%s_sfields", nm), 64'(fld_bad), 64'(0));
    chk($sformatf("%s_mready_busy", nm), 64'(rdy_bad | m_req_ready), 64'(0));
    if (!m_rsp_valid) return;
    rd_hold = m_rdata; err_hold = m_rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!m_rsp_valid || m_rdata !== rd_hold || m_rsp_err !== err_hold || m_req_ready)
        stab_bad = 1;
    end
    if (hold > 0) chk($sformatf("%s_hold", nm), 64'(stab_bad), 64'(0));
    m_rsp_ready = 1'b1;
    @(posedge clk); #1;
    m_rsp_ready = 1'b0;
    chk($sformatf("%s_rsp_drop", nm), 64'(m_rsp_valid), 64'(0));
    chk($sformatf("%s_ready_back", nm), 64'(m_req_ready), 64'(1));
    if (exp_err && exp_cnt < 16'hFFFF) exp_cnt++;
    chk($sformatf("%s_errcnt", nm), 64'(err_count), 64'(exp_cnt));
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    int          rl, sl, hold;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk_reset_vals(input string nm);
    chk($sformatf("%s_mready", nm), 64'(m_req_ready), 64'(1));
    chk($sformatf("%s_mrspv", nm), 64'(m_rsp_valid), 64'(0));
    chk($sformatf("%s_merr", nm), 64'(m_rsp_err), 64'(0));
    chk($sformatf("%s_mrdata", nm), 64'(m_rdata), 64'(0));
    chk($sformatf("%s_sreqv", nm), 64'(s_req_valid), 64'(0));
    chk($sformatf("%s_saddr_we_wd", nm), {15'h0, s_we, s_addr, s_wdata}, 64'(0));
    chk($sformatf("%s_errcnt", nm), 64'(err_count), 64'(0));
  endtask

  initial begin
    bit e; logic [31:0] r; int l;
    rst = 1'b1; m_req_valid = 0; m_addr = 0; m_we = 0; m_wdata = 0; m_rsp_ready = 0;
    slv_data[0] = 32'hDEADBEEF; slv_data[1] = 32'h1111_1111;
    slv_data[2] = 32'h2222_2222; slv_data[3] = 32'h3333_3333;
    #1;
    chk_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    //             addr          we  wdata         rl sl hold err rdata          lat
    tbl[0] = '{32'h0000_0010, 0, 32'h0,         0, 0, 0, 0, 32'hDEADBEEF, 3};
    tbl[1] = '{32'h0003_0004, 1, 32'h0000_0055, 0, 0, 0, 0, 32'h0,        3};
    tbl[2] = '{32'h0004_0000, 0, 32'h0,         0, 0, 0, 1, 32'h0,        1};
    tbl[3] = '{32'h0001_0020, 0, 32'h0,         2, 1, 5, 0, 32'h1111_1111, 6};
    tbl[4] = '{32'hFFFF_0000, 1, 32'hABCD_0123, 0, 0, 2, 1, 32'h0,        1};
    tbl[5] = '{32'h0002_FFFC, 0, 32'h0,         1, 3, 0, 0, 32'h2222_2222, 7};
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].we, tbl[i].wdata, tbl[i].rl,
              tbl[i].sl, 1'b0, tbl[i].hold, tbl[i].exp_err, tbl[i].exp_rd, tbl[i].exp_lat);
    end

    noise_en = 1;
    for (int t = 0; t < 200; t++) begin
      int s, rl, sl, hold;
      logic [31:0] addr, wd;
      bit we;
      s = $urandom_range(0, 5);
      addr = {16'(s), 16'($urandom)};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      rl = $urandom_range(0, 4);
      sl = $urandom_range(0, 4);
      hold = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) slv_data[i] = $urandom;
      ref_model(addr, we, rl, sl, 1'b0, e, r, l);
      run_txn($sformatf("rnd%0d", t), addr, we, wd, rl, sl, 1'b0, hold, e, r, l);
    end
    noise_en = 0;

`ifdef MEM_BUS_ROUTER_TIMEOUT_EN
    slv_data[2] = 32'hCAFE_F00D;
    ref_model(32'h0002_0040, 0, 0, 0, 1'b1, e, r, l);
    run_txn("tmo_norsp", 32'h0002_0040, 0, 0, 0, 0, 1'b1, 0, e, r, l);
    ref_model(32'h0002_0044, 0, 0, TMO - 2, 1'b0, e, r, l);
    run_txn("tmo_sameclk", 32'h0002_0044, 0, 0, 0, TMO - 2, 1'b0, 0, e, r, l);
    ref_model(32'h0002_0048, 0, 1, TMO - 2, 1'b0, e, r, l);
    run_txn("tmo_late", 32'h0002_0048, 0, 0, 1, TMO - 2, 1'b0, 0, e, r, l);
    ref_model(32'h0002_004C, 1, 20, 0, 1'b0, e, r, l);
    run_txn("tmo_nogrant", 32'h0002_004C, 1, 32'h77, 20, 0, 1'b0, 0, e, r, l);
`endif

    // Reset while the router waits on a slave that never answers.
    cur_slv = 1; rdy_lat = 0; rsp_lat = 0; never_rsp = 1;
    m_addr = 32'h0001_0008; m_we = 0; m_wdata = 32'h1234; m_req_valid = 1'b1;
    @(posedge clk); #1;
    m_req_valid = 1'b0;
    chk("rstwait_issue", 64'(s_req_valid), 64'(4'b0010));
    @(posedge clk); #1;
    chk("rstwait_inwait", 64'({s_req_valid, m_rsp_valid, m_req_ready}), 64'(0));
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("rstwait");
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    never_rsp = 0;
    @(posedge clk); #1;
    slv_data[3] = 32'h0BAD_CAFE;
    run_txn("post_rst", 32'h0003_0100, 0, 0, 1, 1, 1'b0, 1, 0, 32'h0BAD_CAFE, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
